// File: rtl/rgb_led_pkg.sv
// Shared types and helpers for the multi-LED PWM driver.
// Pure definitions: no latency, no backpressure.
package rgb_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_SOLID   = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   // Widest duty the scaling helper handles; callers zero-extend into it.
   localparam int SCALE_W = 16;
   localparam int PROD_W  = 2 * SCALE_W;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // (duty * (level + 1)) >> bits: exact duty at level==MAX, zero at level==0.
   function automatic logic [SCALE_W-1:0] breathe_scale(
      input logic [SCALE_W-1:0] duty,
      input logic [SCALE_W-1:0] level,
      input int unsigned        bits
   );
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(duty) * (PROD_W'(level) + PROD_W'(1));
      return SCALE_W'(prod >> bits);
   endfunction

endpackage

// File: rtl/rgb_led_array_channel.sv
// One colour of one LED: picks the effective duty from mode and compares against pwm_cnt.
// Pin registered one cycle after its inputs; no backpressure.
module rgb_pwm_channel
   import rgb_led_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [PWM_BITS-1:0] duty,
   input  mode_t               mode,
   input  logic                blink_on,
   input  logic [PWM_BITS-1:0] level,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                pin
);

   localparam logic OFF_LVL = ACTIVE_LOW;

   logic [PWM_BITS-1:0] eff;
   logic                lit;

   always_comb begin
      eff = '0;
      case (mode)
         MODE_OFF:     eff = '0;
         MODE_SOLID:   eff = duty;
         MODE_BLINK:   eff = blink_on ? duty : '0;
         MODE_BREATHE: eff = PWM_BITS'(breathe_scale(SCALE_W'(duty), SCALE_W'(level), PWM_BITS));
         default:      eff = '0;
      endcase
   end

   assign lit = (pwm_cnt < eff);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pin <= OFF_LVL;
      end else begin
         pin <= lit ^ OFF_LVL;
      end
   end

endmodule

// File: rtl/rgb_led_array.sv
// Drives NUM_LEDS RGB LEDs from double-buffered per-LED config, swapped in at PWM frame boundaries.
// Pins lag counters/config by one cycle; writes are always accepted (no backpressure).
module rgb_led_array
   import rgb_led_pkg::*;
#(
   parameter int NUM_LEDS     = 1,
   parameter int PWM_BITS     = 8,
   parameter int BLINK_PERIOD = 27000000,
   parameter int BREATHE_STEP = 105000,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int IDX_W        = clog2_min1(NUM_LEDS)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  cfg_we,
   input  logic [IDX_W-1:0]      cfg_idx,
   input  logic [3*PWM_BITS-1:0] cfg_rgb,
   input  logic [1:0]            cfg_mode,
   output logic [NUM_LEDS-1:0]   led_r,
   output logic [NUM_LEDS-1:0]   led_g,
   output logic [NUM_LEDS-1:0]   led_b,
   output logic                  frame_start
);

   localparam int BLINK_W = clog2_min1(BLINK_PERIOD);
   localparam int STEP_W  = clog2_min1(BREATHE_STEP);

   localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);
   localparam logic [PWM_BITS-1:0] LVL_MAX    = '1;
   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
   localparam logic [BLINK_W-1:0]  BLINK_HALF = BLINK_W'(BLINK_PERIOD / 2);
   localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(BREATHE_STEP - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [BLINK_W-1:0]  blink_cnt;
   logic [STEP_W-1:0]   step_cnt;
   logic [PWM_BITS-1:0] level;
   logic                level_up;
   logic                boundary;
   logic                blink_on;
   logic                wr_ok;

   logic [3*PWM_BITS-1:0] pend_rgb [NUM_LEDS];
   mode_t                 pend_mode[NUM_LEDS];
   logic [3*PWM_BITS-1:0] act_rgb  [NUM_LEDS];
   mode_t                 act_mode [NUM_LEDS];

   assign boundary = (pwm_cnt == PWM_LAST);
   assign blink_on = (blink_cnt < BLINK_HALF);
   assign wr_ok    = cfg_we && (int'(cfg_idx) < NUM_LEDS);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         step_cnt    <= '0;
         level       <= '0;
         level_up    <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         pwm_cnt     <= boundary ? '0 : pwm_cnt + PWM_BITS'(1);
         blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
         frame_start <= boundary;
         if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            // Endpoints are visited once, then the ramp turns around.
            if (level_up) begin
               if (level == LVL_MAX) begin
                  level    <= level - PWM_BITS'(1);
                  level_up <= 1'b0;
               end else begin
                  level <= level + PWM_BITS'(1);
               end
            end else begin
               if (level == '0) begin
                  level    <= level + PWM_BITS'(1);
                  level_up <= 1'b1;
               end else begin
                  level <= level - PWM_BITS'(1);
               end
            end
         end else begin
            step_cnt <= step_cnt + STEP_W'(1);
         end
      end
   end

   // A write landing on the boundary cycle goes straight into the active bank.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            pend_rgb[i]  <= '0;
            pend_mode[i] <= MODE_OFF;
            act_rgb[i]   <= '0;
            act_mode[i]  <= MODE_OFF;
         end
      end else begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_ok && (int'(cfg_idx) == i)) begin
               pend_rgb[i]  <= cfg_rgb;
               pend_mode[i] <= mode_t'(cfg_mode);
            end
            if (boundary) begin
               if (wr_ok && (int'(cfg_idx) == i)) begin
                  act_rgb[i]  <= cfg_rgb;
                  act_mode[i] <= mode_t'(cfg_mode);
               end else begin
                  act_rgb[i]  <= pend_rgb[i];
                  act_mode[i] <= pend_mode[i];
               end
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
      rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_r (
         .clk      (clk),
         .n_rst    (n_rst),
         .duty     (act_rgb[i][3*PWM_BITS-1:2*PWM_BITS]),
         .mode     (act_mode[i]),
         .blink_on (blink_on),
         .level    (level),
         .pwm_cnt  (pwm_cnt),
         .pin      (led_r[i])
      );
      rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_g (
         .clk      (clk),
         .n_rst    (n_rst),
         .duty     (act_rgb[i][2*PWM_BITS-1:PWM_BITS]),
         .mode     (act_mode[i]),
         .blink_on (blink_on),
         .level    (level),
         .pwm_cnt  (pwm_cnt),
         .pin      (led_g[i])
      );
      rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_b (
         .clk      (clk),
         .n_rst    (n_rst),
         .duty     (act_rgb[i][PWM_BITS-1:0]),
         .mode     (act_mode[i]),
         .blink_on (blink_on),
         .level    (level),
         .pwm_cnt  (pwm_cnt),
         .pin      (led_b[i])
      );
   end

endmodule

// File: doc/rgb_led_array.md
Name: rgb_led_array

Overview:
Multi-channel successor to the single RGB LED PWM driver. It drives NUM_LEDS three-colour LEDs from per-LED configuration written over a simple write port. Each LED has its own mode: off, solid, blink, or breathe (triangle brightness ramp). Configuration is double-buffered and applied only at PWM frame boundaries, so outputs never glitch mid-frame. It sits between the board-control logic and the LED pins.

Parameters:
NUM_LEDS, 1, number of RGB LEDs driven (1..16)
PWM_BITS, 8, duty width per colour; frame = 2^PWM_BITS-1 steps (MAX)
BLINK_PERIOD, 27000000, blink period in clk cycles (1.0 s at 27 MHz); must be even and >=2
BREATHE_STEP, 105000, clk cycles per breathe level step
ACTIVE_LOW, 1, 1 = LED lit when pin is 0 (pull-up wiring)

Ports:
clk  in  1  system clock, 27 MHz
n_rst  in  1  asynchronous reset, active low
cfg_we  in  1  write strobe, one write per cycle, always accepted
cfg_idx  in  IDX_W  target LED; IDX_W = max(1, clog2(NUM_LEDS))
cfg_rgb  in  3*PWM_BITS  {R,G,B} duties
cfg_mode  in  2  0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE
led_r  out  NUM_LEDS  red pins, one bit per LED
led_g  out  NUM_LEDS  green pins
led_b  out  NUM_LEDS  blue pins
frame_start  out  1  one-cycle pulse, registered, high while pwm_cnt==0

Behaviour:
- Reset (async, n_rst=0): all led_* at off level (ACTIVE_LOW ? 1 : 0); frame_start=0; pwm_cnt, blink_cnt, breathe_cnt=0; breathe level L=0, direction up; pending and active rgb=0, mode=OFF. Reset mid-frame forces outputs off immediately.
- pwm_cnt counts 0..MAX-1, then wraps to 0. The wrap cycle (pwm_cnt==MAX-1) is the frame boundary.
- Write: when cfg_we=1 and cfg_idx<NUM_LEDS, the pending slot [idx] takes cfg_rgb/cfg_mode. When cfg_idx>=NUM_LEDS, the write is ignored. Repeated writes within a frame: last wins.
- At the frame boundary, all pending slots are copied to active. A write on the boundary cycle itself bypasses into active at that same boundary.
- Effective duty per colour, from active duty d:
  - OFF: 0.
  - SOLID: d.
  - BLINK: d while blink_cnt < BLINK_PERIOD/2, else 0.
  - BREATHE: (d*(L+1)) >> PWM_BITS, using a 2*PWM_BITS intermediate. This gives exact d at L=MAX and exact 0 at L=0.
- Pin lit when pwm_cnt < eff_duty. duty=0 is fully off; duty=MAX is fully on.
- Outputs are registered: pin at cycle t+1 reflects pwm_cnt and state at cycle t.
- blink_cnt: 0..BLINK_PERIOD-1, free-running and global. It is not reset by writes or mode changes.
- Breathe: breathe_cnt counts 0..BREATHE_STEP-1. On wrap, L steps ±1.
  - Direction reverses on reaching MAX (up) or 0 (down). L sequence: 0,1,…,MAX,MAX-1,…,0,1,…
  - Each endpoint is held one step only. L is global and shared by all BREATHE LEDs.
- L and the blink phase are sampled continuously, not frame-latched.

Decomposition:
- Package rgb_led_pkg:
  - 2-bit mode typedef with constants MODE_OFF/SOLID/BLINK/BREATHE.
  - Function computing the breathe scaling.
  - IDX_W derivation.
- Sub-module rgb_pwm_channel: one colour. Inputs are duty, mode, blink phase, L and pwm_cnt; output is the registered pin. Instantiated 3*NUM_LEDS times.
- Top level holds the counters, the pending/active configuration banks and the write logic.

Test Plan:
- NUM_LEDS=2, PWM_BITS=8. Write idx0 rgb=FF/80/00 SOLID mid-frame. Before the boundary: all pins stay 1. After the boundary: r=0 all 255 cycles, g=0 for 128 cycles per frame, b=1 constant; LED1 remains off.
- Write idx1 SOLID FF/FF/FF exactly on the boundary cycle: lit from the first cycle of the next frame. Two writes to idx1 in one frame (10 then 20): only duty 20 observed.
- BLINK_PERIOD=100, PWM_BITS=4, duty 15 BLINK: pin lit for blink_cnt 0..49 and off for 50..99, over 3 periods.
- PWM_BITS=4, BREATHE_STEP=4, duty 15 BREATHE: L walks 0→15→0 (4 cycles per step). eff=0 at L=0, 7 at L=7, 15 at L=15. Duty 8, L=7: eff=4.
- NUM_LEDS=3, write with idx=3: no slot changes; outputs unchanged.
- Assert n_rst mid-frame with LEDs lit: all pins go to 1 asynchronously. After release, everything is OFF until rewritten; frame_start first pulses when pwm_cnt==0.
